// File: rtl/gate_pkg.sv
// Shared definitions for the gate-library self-test: obs bit positions,
// controller state encoding and the expected gate outputs for each vector.
// No logic; imported by the controller, the lookup and anything that checks them.
package gate_pkg;

  // Bit positions of each gate output within obs / fail_mask
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam int NUM_GATES = 7;
  localparam int NUM_VECS  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Expected obs per vector index ({a,b} = idx), bit order xnor..and
  localparam logic [6:0] EXP_V0 = 7'b1011100;  // a=0 b=0
  localparam logic [6:0] EXP_V1 = 7'b0101110;  // a=0 b=1
  localparam logic [6:0] EXP_V2 = 7'b0101010;  // a=1 b=0
  localparam logic [6:0] EXP_V3 = 7'b1000011;  // a=1 b=1

  // Number of set bits in a 7-bit mismatch vector (0..7)
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int i = 0; i < NUM_GATES; i++) begin
      sum = sum + {2'b00, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Truth-table lookup: 2-bit vector index to the seven expected gate outputs.
// Latency: purely combinational.
// No flow control; output follows idx_i directly.
module gate_expect
  import gate_pkg::*;
(
  input  logic [1:0] idx_i,
  output logic [6:0] exp_o
);

  // Select the stored expected vector for the current index
  always_comb begin
    exp_o = EXP_V0;
    case (idx_i)
      2'd0:    exp_o = EXP_V0;
      2'd1:    exp_o = EXP_V1;
      2'd2:    exp_o = EXP_V2;
      2'd3:    exp_o = EXP_V3;
      default: exp_o = EXP_V0;
    endcase
  end

endmodule

// File: rtl/gate_bist.sv
// Self-test controller for the seven-gate bank: steps {a,b} through 00..11,
// waits SETTLE_CYCLES+1 cycles per vector, accumulates per-gate mismatches.
// Latency: done 4*(SETTLE_CYCLES+1) edges after start; start ignored while busy.
module gate_bist
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2  // legal 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] obs,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [4:0] err_cnt
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [1:0] idx_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [6:0] fail_mask_q;
  logic [4:0] err_cnt_q;

  logic [6:0] exp_vec;
  logic [6:0] mismatch;
  logic [6:0] fail_mask_d;
  logic [4:0] err_cnt_d;
  logic [1:0] idx_d;

  gate_expect u_expect (
    .idx_i (idx_q),
    .exp_o (exp_vec)
  );

  // Accumulator next values, only committed in the CHECK cycle
  always_comb begin
    mismatch    = obs ^ exp_vec;
    fail_mask_d = fail_mask_q | mismatch;
    err_cnt_d   = err_cnt_q + {2'b00, popcount7(mismatch)};
    idx_d       = idx_q + 2'd1;
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 7'd0;
      err_cnt_q   <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SETTLE;
            busy_q      <= 1'b1;
            fail_mask_q <= 7'd0;
            err_cnt_q   <= 5'd0;
            pass_q      <= 1'b0;
            idx_q       <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cnt_q       <= 4'd0;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          fail_mask_q <= fail_mask_d;
          err_cnt_q   <= err_cnt_d;
          if (idx_q == 2'd3) begin
            // Pass reflects this final compare, not the stale mask
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (fail_mask_d == 7'd0);
          end else begin
            state_q <= SETTLE;
            idx_q   <= idx_d;
            a_q     <= idx_d[1];
            b_q     <= idx_d[0];
            cnt_q   <= 4'd0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: behavioural gate bank with injectable faults drives obs,
// and a truth-table model predicts fail_mask, err_cnt, pass and run timing.
module tb_gate_bist;

  localparam int S   = 2;
  localparam int LAT = 4 * (S + 1);  // start edge to done cycle
  localparam int PER = LAT + 2;      // done to done with start held high

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] obs;
  logic       a, b, busy, done, pass;
  logic [6:0] fail_mask;
  logic [4:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Fault mode of the gate bank: 0 good, 1 xor stuck 0, 2 nand/nor swapped,
  // 3 all ones, 4 random bit flips per vector
  int         mode;
  logic [6:0] flip_tbl [4];

  always #5 clk = ~clk;

  gate_bist #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .obs       (obs),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal gate outputs from the boolean definitions
  function automatic logic [6:0] good_of(input logic av, input logic bv);
    return {~(av ^ bv), av ^ bv, ~(av | bv), ~(av & bv), ~av, av | bv, av & bv};
  endfunction

  function automatic logic [6:0] bank_of(input int m, input logic av, input logic bv);
    logic [6:0] g;
    g = good_of(av, bv);
    case (m)
      1: g[5] = 1'b0;
      2: g = {g[6], g[5], g[3], g[4], g[2], g[1], g[0]};
      3: g = 7'h7F;
      4: g = g ^ flip_tbl[{av, bv}];
      default: ;
    endcase
    return g;
  endfunction

  always_comb obs = bank_of(mode, a, b);

  // Reference: sum mismatches over all four vectors for the current fault mode
  task automatic model(output logic [6:0] m, output logic [4:0] e);
    logic [6:0] diff;
    m = '0;
    e = '0;
    for (int v = 0; v < 4; v++) begin
      diff = bank_of(mode, v[1], v[0]) ^ good_of(v[1], v[0]);
      m |= diff;
      for (int i = 0; i < 7; i++) e += {4'd0, diff[i]};
    end
  endtask

  // One full run; poke >= 0 pulses start again at that cycle offset
  task automatic do_run(input string tag, input int poke);
    int         lat;
    bit         seq_bad, busy_bad;
    logic [1:0] vexp;
    logic [6:0] m_exp;
    logic [4:0] e_exp;
    lat = -1; seq_bad = 0; busy_bad = 0;
    model(m_exp, e_exp);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c <= LAT + 10; c++) begin
      start = (c == poke);
      if (c < LAT) begin
        vexp = 2'(c / (S + 1));
        if ({a, b} !== vexp) seq_bad = 1;
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk) start = 1'b0;
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_ab_seq_ok"}, !seq_bad, 1);
    chk({tag, "_busy_ok"}, !busy_bad, 1);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_mask"}, fail_mask, m_exp);
    chk({tag, "_errcnt"}, err_cnt, e_exp);
    chk({tag, "_pass"}, pass, (m_exp == 7'd0));
    repeat (3) @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_mask_hold"}, fail_mask, m_exp);
    chk({tag, "_err_hold"}, err_cnt, e_exp);
  endtask

  initial begin
    logic [6:0] part;
    bit         saw_done;
    int         gap;

    rst = 1'b1; start = 1'b0; mode = 0;
    for (int i = 0; i < 4; i++) flip_tbl[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ab", {a, b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed fault cases with hand-known results
    mode = 0; do_run("good", -1);
    chk("good_pass_k", pass, 1);
    mode = 1; do_run("xor0", -1);
    chk("xor0_mask_k", fail_mask, 7'b0100000);
    chk("xor0_err_k", err_cnt, 2);
    mode = 2; do_run("swap", -1);
    chk("swap_mask_k", fail_mask, 7'b0011000);
    chk("swap_err_k", err_cnt, 4);
    mode = 3; do_run("ones", -1);
    chk("ones_mask_k", fail_mask, 7'h7F);
    chk("ones_err_k", err_cnt, 14);

    // start pulses mid-run and during the done cycle are ignored
    mode = 0; do_run("poke_mid", 5);
    mode = 1; do_run("poke_done", LAT);

    // Randomized fault patterns
    mode = 4;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++)
        flip_tbl[i] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
      do_run("rand", -1);
    end

    // Reset during the settle phase of vector 2
    mode = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2 * (S + 1) + 1) @(negedge clk);
    part = ~good_of(1'b0, 1'b0) | ~good_of(1'b0, 1'b1);
    chk("mid_mask_partial", fail_mask, part);
    chk("mid_ab", {a, b}, 2'b10);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ab", {a, b}, 0);
    chk("mid_rst_mask", fail_mask, 0);
    chk("mid_rst_err", err_cnt, 0);
    saw_done = 0;
    for (int c = 0; c < LAT + 8; c++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    chk("mid_rst_quiet", saw_done, 0);
    mode = 0; do_run("after_rst", -1);

    // start held high: back-to-back runs
    mode = 2;
    @(negedge clk) start = 1'b1;
    gap = -1;
    for (int c = 0; c < 3 * PER; c++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    for (int k = 0; k < 2; k++) begin
      gap = -1;
      for (int c = 1; c <= PER + 5; c++) begin
        @(negedge clk);
        if (done === 1'b1) begin gap = c; break; end
      end
      chk("b2b_period", gap, PER);
      chk("b2b_mask", fail_mask, 7'b0011000);
    end
    start = 1'b0;
    for (int c = 0; c < 2 * PER; c++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    chk("b2b_drain", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
